// File: rtl/pe_tile_generic.sv
// Parametrised programmable logic tile: two connect boxes, a registered CLB and a
// switch box, configured through an addressed register bus with read-back.
module pe_tile_generic #(
    parameter int         WIDTH      = 1,
    parameter int         NUM_TRACKS = 4,
    parameter logic [3:0] EDGE_MASK  = 4'b0000,
    parameter int         SEL_W      = $clog2(2 * NUM_TRACKS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [15:0]                     tile_id,
    input  logic [31:0]                     config_addr,
    input  logic [31:0]                     config_data,
    input  logic                            config_valid,
    input  logic                            config_we,
    output logic                            config_resp_valid,
    output logic [31:0]                     config_rdata,
    output logic                            config_err,
    input  logic [4*NUM_TRACKS*WIDTH-1:0]   in_wires,
    output logic [4*NUM_TRACKS*WIDTH-1:0]   out_wires
);
    localparam int NSB  = 4 * NUM_TRACKS;
    localparam int NREG = 3 + NSB;

    logic [SEL_W-1:0] cb0_sel, cb1_sel;
    logic [2:0]       clb_op;
    logic [2:0]       sb_cfg  [NSB];
    logic [WIDTH-1:0] sb_comb [NSB];
    logic [WIDTH-1:0] sb_q_p1 [NSB];
    logic [WIDTH-1:0] acc_p1, pe_out_p1;
    logic [WIDTH-1:0] op0, op1, acc_next, clb_next;

    logic             cfg_hit, cfg_wr, cfg_mapped;
    logic [7:0]       cfg_id;
    logic [31:0]      cfg_wval, cfg_rval;
    logic             unused_data;

    function automatic logic [WIDTH-1:0] add_wrap(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        return a + b;
    endfunction

    // Selects below NUM_TRACKS read the inputs, the next NUM_TRACKS read our own outputs.
    function automatic logic [WIDTH-1:0] cb_pick(input logic [SEL_W-1:0] sel,
                                                 input logic [4*NUM_TRACKS*WIDTH-1:0] iw,
                                                 input logic [4*NUM_TRACKS*WIDTH-1:0] ow);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int t = 0; t < NUM_TRACKS; t++) begin
            if (int'(sel) == t) r = iw[t*WIDTH +: WIDTH];
            if (int'(sel) == t + NUM_TRACKS) r = ow[t*WIDTH +: WIDTH];
        end
        return r;
    endfunction

    function automatic int other_side(input int s, input int k);
        return (k < s) ? k : k + 1;
    endfunction

    assign cfg_id      = config_addr[7:0];
    assign cfg_hit     = config_valid && (config_addr[31:16] == tile_id) &&
                         (config_addr[15:8] == 8'd0);
    assign cfg_wr      = cfg_hit && config_we;
    assign cfg_mapped  = (int'(cfg_id) < NREG);
    assign unused_data = ^config_data;

    always_comb begin
        cfg_rval = '0;
        cfg_wval = '0;
        if (cfg_id == 8'd0) begin
            cfg_rval[SEL_W-1:0] = cb0_sel;
            cfg_wval[SEL_W-1:0] = config_data[SEL_W-1:0];
        end else if (cfg_id == 8'd1) begin
            cfg_rval[SEL_W-1:0] = cb1_sel;
            cfg_wval[SEL_W-1:0] = config_data[SEL_W-1:0];
        end else if (cfg_id == 8'd2) begin
            cfg_rval[2:0] = clb_op;
            cfg_wval[2:0] = config_data[2:0];
        end
        for (int i = 0; i < NSB; i++) begin
            if (int'(cfg_id) == 3 + i) begin
                cfg_rval[2:0] = sb_cfg[i];
                cfg_wval[2:0] = config_data[2:0];
            end
        end
    end

    always_comb begin
        op0      = cb_pick(cb0_sel, in_wires, out_wires);
        op1      = cb_pick(cb1_sel, in_wires, out_wires);
        acc_next = add_wrap(acc_p1, op0);
        case (clb_op)
            3'd0:    clb_next = op0 & op1;
            3'd1:    clb_next = op0 | op1;
            3'd2:    clb_next = op0 ^ op1;
            3'd3:    clb_next = ~op0;
            3'd4:    clb_next = add_wrap(op0, op1);
            3'd5:    clb_next = op0;
            3'd6:    clb_next = acc_next;
            default: clb_next = op1;
        endcase
    end

    always_comb begin
        for (int s = 0; s < 4; s++) begin
            for (int t = 0; t < NUM_TRACKS; t++) begin
                if (sb_cfg[s*NUM_TRACKS+t][1:0] == 2'd3)
                    sb_comb[s*NUM_TRACKS+t] = pe_out_p1;
                else
                    sb_comb[s*NUM_TRACKS+t] = in_wires[(other_side(s, int'(sb_cfg[s*NUM_TRACKS+t][1:0]))
                                                        * NUM_TRACKS + t) * WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        out_wires = '0;
        for (int s = 0; s < 4; s++) begin
            for (int t = 0; t < NUM_TRACKS; t++) begin
                if (!EDGE_MASK[s])
                    out_wires[(s*NUM_TRACKS+t)*WIDTH +: WIDTH] =
                        sb_cfg[s*NUM_TRACKS+t][2] ? sb_q_p1[s*NUM_TRACKS+t] : sb_comb[s*NUM_TRACKS+t];
            end
        end
    end

    // Stage p1: config registers, CLB result, SB output flops and bus response.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cb0_sel           <= '0;
            cb1_sel           <= '0;
            clb_op            <= '0;
            acc_p1            <= '0;
            pe_out_p1         <= '0;
            config_resp_valid <= 1'b0;
            config_rdata      <= '0;
            config_err        <= 1'b0;
            for (int i = 0; i < NSB; i++) begin
                sb_cfg[i]  <= '0;
                sb_q_p1[i] <= '0;
            end
        end else begin
            config_resp_valid <= cfg_hit;
            config_err        <= cfg_hit && !cfg_mapped;
            config_rdata      <= (cfg_hit && cfg_mapped) ? (config_we ? cfg_wval : cfg_rval) : 32'd0;
            if (cfg_wr) begin
                if (cfg_id == 8'd0) cb0_sel <= config_data[SEL_W-1:0];
                if (cfg_id == 8'd1) cb1_sel <= config_data[SEL_W-1:0];
                if (cfg_id == 8'd2) clb_op  <= config_data[2:0];
                for (int i = 0; i < NSB; i++) begin
                    if (int'(cfg_id) == 3 + i) sb_cfg[i] <= config_data[2:0];
                end
            end
            // Reprogramming the CLB restarts it from a clean state.
            if (cfg_wr && cfg_id == 8'd2) begin
                acc_p1    <= '0;
                pe_out_p1 <= '0;
            end else begin
                pe_out_p1 <= clb_next;
                if (clb_op == 3'd6) acc_p1 <= acc_next;
            end
            for (int i = 0; i < NSB; i++) sb_q_p1[i] <= sb_comb[i];
        end
    end

endmodule

// File: tb/tb_pe_tile_generic.sv
// Directed bench for pe_tile_generic: four tiles of differing geometry on one
// shared config bus, with a response scoreboard and directed data checks.
module tb_pe_tile_generic;
    localparam int ND = 4;
    localparam logic [15:0] TID [ND] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    localparam int NT_OF [ND] = '{4, 3, 4, 4};
    localparam int ACC_SEQ [4] = '{5, 10, 15, 4};

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] config_addr, config_data;
    logic        config_valid, config_we;
    logic        resp_v [ND];
    logic [31:0] rdata  [ND];
    logic        err    [ND];
    logic [15:0] iw0, ow0, iw3, ow3;
    logic [11:0] iw1, ow1;
    logic [63:0] iw2, ow2;

    typedef struct { int dut; logic [31:0] rdata; logic err; } resp_t;
    resp_t       sbq [$];
    logic [31:0] shadow [ND][256];
    int          compared = 0;
    int          mismatched = 0;

    always #5 clk = ~clk;

    pe_tile_generic #(.WIDTH(1), .NUM_TRACKS(4), .EDGE_MASK(4'b0000)) u0 (
        .clk(clk), .reset(reset), .tile_id(TID[0]), .config_addr(config_addr),
        .config_data(config_data), .config_valid(config_valid), .config_we(config_we),
        .config_resp_valid(resp_v[0]), .config_rdata(rdata[0]), .config_err(err[0]),
        .in_wires(iw0), .out_wires(ow0));
    pe_tile_generic #(.WIDTH(1), .NUM_TRACKS(3), .EDGE_MASK(4'b0000)) u1 (
        .clk(clk), .reset(reset), .tile_id(TID[1]), .config_addr(config_addr),
        .config_data(config_data), .config_valid(config_valid), .config_we(config_we),
        .config_resp_valid(resp_v[1]), .config_rdata(rdata[1]), .config_err(err[1]),
        .in_wires(iw1), .out_wires(ow1));
    pe_tile_generic #(.WIDTH(4), .NUM_TRACKS(4), .EDGE_MASK(4'b0000)) u2 (
        .clk(clk), .reset(reset), .tile_id(TID[2]), .config_addr(config_addr),
        .config_data(config_data), .config_valid(config_valid), .config_we(config_we),
        .config_resp_valid(resp_v[2]), .config_rdata(rdata[2]), .config_err(err[2]),
        .in_wires(iw2), .out_wires(ow2));
    pe_tile_generic #(.WIDTH(1), .NUM_TRACKS(4), .EDGE_MASK(4'b0100)) u3 (
        .clk(clk), .reset(reset), .tile_id(TID[3]), .config_addr(config_addr),
        .config_data(config_data), .config_valid(config_valid), .config_we(config_we),
        .config_resp_valid(resp_v[3]), .config_rdata(rdata[3]), .config_err(err[3]),
        .in_wires(iw3), .out_wires(ow3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_shadow();
        for (int d = 0; d < ND; d++)
            for (int i = 0; i < 256; i++) shadow[d][i] = 32'd0;
    endtask

    task automatic check_resp();
        resp_t e;
        for (int k = 0; k < ND; k++) begin
            if (sbq.size() > 0 && sbq[0].dut == k) begin
                e = sbq.pop_front();
                chk($sformatf("resp_valid%0d", k), 32'(resp_v[k]), 32'd1);
                chk($sformatf("rdata%0d", k), rdata[k], e.rdata);
                chk($sformatf("err%0d", k), 32'(err[k]), 32'(e.err));
            end else begin
                chk($sformatf("resp_idle%0d", k), 32'(resp_v[k]), 32'd0);
            end
        end
    endtask

    task automatic cfg(input logic [15:0] tid, input logic [7:0] mid, input logic [7:0] id,
                       input logic we, input logic [31:0] data);
        int          d;
        resp_t       e;
        logic [31:0] msk;
        d = -1;
        for (int k = 0; k < ND; k++) if (tid == TID[k] && mid == 8'd0) d = k;
        config_addr  = {tid, mid, id};
        config_data  = data;
        config_we    = we;
        config_valid = 1'b1;
        if (d >= 0) begin
            e.dut = d;
            if (int'(id) >= 3 + 4 * NT_OF[d]) begin
                e.rdata = 32'd0;
                e.err   = 1'b1;
            end else begin
                msk = (id < 8'd2) ? ((32'd1 << $clog2(2 * NT_OF[d])) - 32'd1) : 32'd7;
                if (we) shadow[d][id] = data & msk;
                e.rdata = shadow[d][id];
                e.err   = 1'b0;
            end
            sbq.push_back(e);
        end
        tick();
        config_valid = 1'b0;
        check_resp();
    endtask

    initial begin
        reset = 1'b0; config_valid = 1'b0; config_we = 1'b0;
        config_addr = '0; config_data = '0;
        iw0 = '0; iw1 = '0; iw2 = '0; iw3 = '0;
        clear_shadow();
        tick();
        tick();
        reset = 1'b1;
        for (int k = 0; k < ND; k++) chk($sformatf("rst_resp%0d", k), 32'(resp_v[k]), 32'd0);
        chk("rst_ow0", 32'(ow0), 32'd0);

        // register map after reset, reads must not write
        for (int i = 0; i < 20; i++) cfg(TID[0], 8'h00, 8'(i), 1'b0, 32'hFFFF_FFFF);

        // connect box wrap onto own output N1 (fed from E1)
        cfg(TID[0], 8'h00, 8'd15, 1'b1, 32'h3);
        cfg(TID[0], 8'h00, 8'd0,  1'b1, 32'hFFFF_FFFD);
        cfg(TID[0], 8'h00, 8'd2,  1'b1, 32'h5);
        chk("cb_pe_clr", 32'(ow0[12]), 32'd0);
        iw0[5] = 1'b1;
        #1;
        chk("cb_sb_n1", 32'(ow0[1]), 32'd1);
        tick();
        chk("cb_wrap_pe1", 32'(ow0[12]), 32'd1);
        iw0[5] = 1'b0;
        tick();
        chk("cb_wrap_pe0", 32'(ow0[12]), 32'd0);

        // three-track tile: selects 6 and 7 are out of range
        iw1 = '1;
        cfg(TID[1], 8'h00, 8'd12, 1'b1, 32'h3);
        cfg(TID[1], 8'h00, 8'd0,  1'b1, 32'h3);
        cfg(TID[1], 8'h00, 8'd2,  1'b1, 32'h5);
        chk("cb3_pe_clr", 32'(ow1[9]), 32'd0);
        tick();
        chk("cb3_pe", 32'(ow1[9]), 32'd1);
        cfg(TID[1], 8'h00, 8'd0, 1'b1, 32'h6);
        chk("cb3_old_sel", 32'(ow1[9]), 32'd1);
        tick();
        chk("cb3_sel6", 32'(ow1[9]), 32'd0);
        cfg(TID[1], 8'h00, 8'd0, 1'b1, 32'h7);
        tick();
        chk("cb3_sel7", 32'(ow1[9]), 32'd0);

        // accumulate with 4-bit wrap
        iw2[3:0] = 4'h5;
        cfg(TID[2], 8'h00, 8'd15, 1'b1, 32'h3);
        cfg(TID[2], 8'h00, 8'd2,  1'b1, 32'h6);
        chk("acc_clr", 32'(ow2[51:48]), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("acc_step%0d", i), 32'(ow2[51:48]), 32'(ACC_SEQ[i]));
        end
        cfg(TID[2], 8'h00, 8'd2, 1'b1, 32'h6);
        chk("acc_rewrite_clr", 32'(ow2[51:48]), 32'd0);
        tick();
        chk("acc_restart", 32'(ow2[51:48]), 32'd5);

        // switch box register enable on N2
        cfg(TID[0], 8'h00, 8'd5, 1'b1, 32'h3);
        iw0[5] = 1'b1;
        tick();
        chk("sbc_pe", 32'(ow0[12]), 32'd1);
        chk("sbc_n2", 32'(ow0[2]), 32'd1);
        iw0[5] = 1'b0;
        tick();
        chk("sbc_n2_0", 32'(ow0[2]), 32'd0);
        cfg(TID[0], 8'h00, 8'd5, 1'b1, 32'h7);
        iw0[5] = 1'b1;
        tick();
        chk("sbr_pe", 32'(ow0[12]), 32'd1);
        chk("sbr_n2_lag", 32'(ow0[2]), 32'd0);
        tick();
        chk("sbr_n2", 32'(ow0[2]), 32'd1);

        // edge mask on the south side
        for (int t = 0; t < 4; t++) cfg(TID[3], 8'h00, 8'(11 + t), 1'b1, 32'h3);
        cfg(TID[3], 8'h00, 8'd3,  1'b1, 32'h3);
        cfg(TID[3], 8'h00, 8'd7,  1'b1, 32'h3);
        cfg(TID[3], 8'h00, 8'd15, 1'b1, 32'h3);
        cfg(TID[3], 8'h00, 8'd2,  1'b1, 32'h3);
        tick();
        chk("mask_s", 32'(ow3[11:8]), 32'd0);
        chk("mask_n0", 32'(ow3[0]), 32'd1);
        chk("mask_e0", 32'(ow3[4]), 32'd1);
        chk("mask_w0", 32'(ow3[12]), 32'd1);
        cfg(TID[3], 8'h00, 8'd11, 1'b0, 32'h0);

        // address filtering
        cfg(16'h0099, 8'h00, 8'd2, 1'b1, 32'h0);
        chk("filt_pe", 32'(ow0[12]), 32'd1);
        cfg(TID[0], 8'h01, 8'd0, 1'b1, 32'h2);
        cfg(TID[0], 8'h00, 8'd0, 1'b0, 32'h0);
        cfg(TID[0], 8'h00, 8'd2, 1'b0, 32'h0);

        // reset dominates a same-cycle write
        reset = 1'b0;
        config_addr = {TID[0], 8'h00, 8'h00};
        config_data = 32'h3;
        config_we = 1'b1;
        config_valid = 1'b1;
        tick();
        config_valid = 1'b0;
        reset = 1'b1;
        clear_shadow();
        check_resp();
        iw0 = '0;
        #1;
        chk("rst_w0", 32'(ow0[12]), 32'd0);
        cfg(TID[0], 8'h00, 8'd0,  1'b0, 32'h0);
        cfg(TID[0], 8'h00, 8'd15, 1'b0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/pe_tile_generic.md
# pe_tile_generic

Parametrised successor to the fixed-size bottom-left PE tile: one programmable logic element (two connect boxes, CLB, switch box) with configurable data width, track count and edge position. Adds a registered PE output, optional per-output pipeline registers, accumulate/delay CLB modes, and a config read-back/response channel. It is instantiated across the array, so one RTL covers corner, edge and interior tiles.

## Interface
- WIDTH, 1: bits per track.
- NUM_TRACKS, 4: tracks per side (≥2).
- EDGE_MASK, 4'b0000: bit s=1 ties all side-s outputs to 0.
- SEL_W, $clog2(2*NUM_TRACKS): connect-box select width (derived).

- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-low.
- tile_id  in  16  this tile's address.
- config_addr  in  32  [31:16] tile match, [15:8] must be 0, [7:0] register id.
- config_data  in  32  write data.
- config_valid  in  1  transaction strobe, one cycle per transaction.
- config_we  in  1  1=write, 0=read; sampled with config_valid.
- config_resp_valid  out  1  response for a matched transaction.
- config_rdata  out  32  register value, zero-extended.
- config_err  out  1  matched transaction hit an unmapped register.
- in_wires  in  4*NUM_TRACKS*WIDTH  side s, track t at bit ((s*NUM_TRACKS)+t)*WIDTH.
- out_wires  out  4*NUM_TRACKS*WIDTH  same packing.

## Operation
- Sides: 0=N, 1=E, 2=S, 3=W.
- Match: config_addr[31:16]==tile_id and [15:8]==0. Unmatched transactions: no state change, no response.
- Register map (ids):
  - 0 cb0_sel[SEL_W-1:0].
  - 1 cb1_sel[SEL_W-1:0].
  - 2 clb_op[2:0].
  - 3 .. 3+4*NUM_TRACKS-1: sb_cfg for side s, track t at id 3+s*NUM_TRACKS+t; bits [1:0] source, bit [2] register enable.
  - Other ids: unmapped. Write ignored; response has rdata 0, err 1.
- Writes take only the listed low bits. Upper bits are dropped and read back as 0.
- Connect box: sel<NUM_TRACKS picks in_wires side 0 track sel. sel≥NUM_TRACKS picks out_wires side 0 track sel-NUM_TRACKS. sel≥2*NUM_TRACKS gives 0. cb0 drives op0, cb1 drives op1.
- CLB (pe_out is registered):
  - 0 AND, 1 OR, 2 XOR, 3 ~op0, 4 op0+op1 mod 2^WIDTH.
  - 5 delay: pe_out<=op0.
  - 6 accumulate: acc<=acc+op0 mod 2^WIDTH, pe_out<=new acc.
  - 7 pass op1.
- A write to id 2 clears acc and pe_out to 0 on that edge, overriding the CLB update.
- Switch box, output side s track t:
  - source 0..2 selects track t of the three other sides, ascending side order, skipping s.
  - source 3 selects pe_out.
  - Register enable 1 inserts one flop; 0 is combinational.
  - Sides in EDGE_MASK output 0 regardless of config.

## Timing
- Reset (reset==0 at edge) zeroes all config registers, acc, pe_out, SB output flops, config_resp_valid, config_rdata and config_err. Reset dominates any same-cycle config transaction.
- Reset config: CBs select in side 0 track 0, CLB AND, SB outputs combinational from the lowest other side.
- Config write: new value effective in the cycle after the edge. The write cycle itself uses the old config.
- Response: config_resp_valid, rdata and err appear one cycle after the matched valid cycle and last exactly one cycle. A write response returns the newly written value. Back-to-back transactions give back-to-back responses.
- Data latency from a CB input to pe_out is 1 cycle, plus 1 cycle if the SB output flop is enabled.
- Combinational SB-to-SB loops between tiles are the configuration's responsibility. Paths through the CLB are always broken by the pe_out register.

## Test plan
- Reset and config map: NUM_TRACKS=4, WIDTH=1. Hold reset low 2 cycles, release, read ids 0..18 -> each rdata 0, err 0. Read id 19 -> err 1, rdata 0.
- Connect box wrap: write cb0_sel=5, set the side 0 track 1 output (via SB) to 1 -> op0=1, so with clb_op=5 pe_out=1 one cycle later. Write cb0_sel=7 with SEL_W widened test (NUM_TRACKS=3) sel=6 -> op0=0.
- Accumulate: WIDTH=4, clb_op=6, hold op0=5 for 4 cycles -> pe_out sequence 5, A, F, 4 (wrap). Rewrite clb_op=6 -> pe_out=0 next cycle.
- SB register enable: route pe_out to N track 2, first with bit2=0 and then with bit2=1 -> out changes in the same cycle as pe_out, then one cycle later.
- Edge mask: EDGE_MASK=4'b0100, configure S outputs from pe_out=1 -> all S outputs stay 0. N/E/W outputs follow config.
- Address filtering and reset override: write with wrong tile_id, then with addr[15:8]=1 -> no response, no change. Assert reset in the same cycle as a valid write -> register stays 0, no response.
